fp_vector_logger: RTL
=====================

# fp_vector_logger

Synthesizable capture block that sits beside `fp_unit` and turns each completed floating-point operation into one 156-bit test-vector record, in the same layout the `fpu.dat` vector reader consumes. Issued operands are queued in an in-flight FIFO. Each `ready` from the unit pops the oldest entry, merges in the result and flags, and pushes the record into an output buffer. The buffer drains over a valid/ready handshake to a trace sink (trace RAM, UART packer). This lets silicon or emulation runs produce vector files that replay directly in simulation.

## Interface
Parameters:
- `INFLIGHT_DEPTH`, 8: in-flight FIFO entries; power of two, ≥ 2; must exceed the unit's maximum outstanding ops.
- `OUT_DEPTH`, 4: output record FIFO entries; power of two, ≥ 2.

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fp_exe_i`  in  `fp_exe_in_type`  the same request bundle driven into `fp_unit`.
- `fp_exe_o`  in  `fp_exe_out_type`  the `fp_unit` response bundle (`result`, `flags`, `ready`).
- `rec_data`  out  156  record at the head of the output FIFO.
- `rec_valid`  out  1  `rec_data` is valid.
- `rec_ready`  in  1  sink accepts the record.
- `err_overflow`  out  1  sticky: issue arrived while the in-flight FIFO was full.
- `err_drop`  out  1  sticky: completion arrived while the output FIFO was full.
- `err_orphan`  out  1  sticky: `ready` arrived with the in-flight FIFO empty.
- `rec_count`  out  32  records accepted by the sink; wraps modulo 2^32.

## Operation
- Issue condition: `enable` and any of `fmadd`, `fadd`, `fsub`, `fmul`, `fdiv`, `fsqrt`, `fcmp`, `fcvt_i2f`, `fcvt_f2i`.
- On issue, push the following into the in-flight FIFO:
  - `data1`, `data2`, `data3`, `rm`, and `fcvt_op` (as `op`).
  - A 10-bit opcode: bit0 fmadd, bit1 fadd, bit2 fsub, bit3 fmul, bit4 fdiv, bit5 fsqrt, bit6 fcmp, bit7 0, bit8 fcvt_i2f, bit9 fcvt_f2i.
- On `fp_exe_o.ready`, pop the oldest entry and build the record:
  - [155:124] data1, [123:92] data2, [91:60] data3, [59:28] result.
  - [27:25] 0, [24:20] flags, [19] 0, [18:16] rm.
  - [15:14] 0, [13:12] op, [11:10] 0, [9:0] opcode.
- Push the record into the output FIFO. Pop the output FIFO when `rec_valid && rec_ready`, and increment `rec_count` on each pop.
- State machine:
  - RUN: normal operation.
  - HALT: entered on any error. No further issues are captured and no completions are recorded. The output FIFO keeps draining.
  - HALT exits only on reset.
- Errors:
  - Issue with the in-flight FIFO full and no pop in the same cycle: set `err_overflow`, go to HALT, drop the op.
  - Completion with the output FIFO full and no pop in the same cycle: set `err_drop`, go to HALT, still pop the in-flight entry.
  - `ready` with the in-flight FIFO empty: set `err_orphan`, go to HALT.
- Issue and completion in the same cycle: both take effect. Full and empty checks use the pre-cycle count adjusted for the simultaneous pop.
- A `ready` in the issue cycle always completes an earlier op, never the op being issued in that cycle.

## Timing
- Reset values: `rec_valid` 0, `rec_data` 0, all `err_*` 0, `rec_count` 0, both FIFOs empty, state RUN.
- Capture latency: a completion in cycle N gives `rec_valid` = 1 in cycle N+1 when the output FIFO was empty.
- `rec_data` and `rec_valid` are registered outputs. Once valid, `rec_data` holds until accepted.
- Throughput: one issue, one completion, and one sink pop per cycle, sustained.
- `rec_valid` drops the cycle after the last record is popped.
- Reset mid-operation clears both FIFOs immediately (asynchronous). Any records in flight are lost.

## Structure
- Shared package `fp_wire`:
  - `fp_vec_rec_type`: packed 156-bit record struct matching the field layout above.
  - `fp_vec_opcode` bit-position constants.
  - `fp_vec_inflight_type`: packed in-flight entry.
- Sub-module `fp_vec_fifo`: parameterized `WIDTH`/`DEPTH` synchronous FIFO with `push`, `pop`, `full`, `empty`, and registered head output. Instantiate it twice.

## Test plan
- Single fadd: data1 0x3F800000, data2 0x40000000, rm 0; unit returns 0x40400000, flags 0 → one record with result 0x40400000, flags 0, opcode 0x002; `rec_count` = 1 after accept.
- Back-to-back: fmul 0x40000000×0x40400000 (returns 0x40C00000) then fdiv 0x3F800000/0 (returns 0x7F800000, flags 0x08) → records emitted in issue order with correct results and flags.
- Backpressure: hold `rec_ready` = 0 and complete 4 ops → `rec_valid` stays 1 and `rec_data` is stable; a 5th completion sets `err_drop` and enters HALT; releasing `rec_ready` drains exactly 4 records.
- Overflow: issue 9 ops with `INFLIGHT_DEPTH` 8 and no completions → `err_overflow` = 1; later completions produce no new records.
- Orphan: `ready` pulse after reset with no issue → `err_orphan` = 1 and no record is emitted.
- Reset mid-stream: assert `reset` low while 3 records are queued → `rec_valid` is 0 and `rec_count` is 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fp_vector_logger_pkg.sv
// fp_wire: shared types for the fp_unit request/response bundles and for the
// test-vector logger that sits beside the unit.
//   fp_exe_in_type       request bundle driven into fp_unit
//   fp_exe_out_type      fp_unit response (result, flags, ready)
//   fp_vec_rec_type      156-bit vector record, fpu.dat field layout
//   fp_vec_inflight_type operands/opcode of an issued op awaiting its result
//   fp_vec_state_e       logger run state
package fp_wire;

    localparam int FP_VEC_REC_W = 156;
    localparam int FP_VEC_OPC_W = 10;

    // Opcode bit positions inside the record's 10-bit opcode field.
    localparam int FP_VEC_OPCODE_FMADD    = 0;
    localparam int FP_VEC_OPCODE_FADD     = 1;
    localparam int FP_VEC_OPCODE_FSUB     = 2;
    localparam int FP_VEC_OPCODE_FMUL     = 3;
    localparam int FP_VEC_OPCODE_FDIV     = 4;
    localparam int FP_VEC_OPCODE_FSQRT    = 5;
    localparam int FP_VEC_OPCODE_FCMP     = 6;
    localparam int FP_VEC_OPCODE_FCVT_I2F = 8;
    localparam int FP_VEC_OPCODE_FCVT_F2I = 9;

    typedef struct packed {
        logic       fmadd;
        logic       fadd;
        logic       fsub;
        logic       fmul;
        logic       fdiv;
        logic       fsqrt;
        logic       fcmp;
        logic       fcvt_i2f;
        logic       fcvt_f2i;
        logic [1:0] fcvt_op;
    } fp_operation_type;

    typedef struct packed {
        logic [31:0]      data1;
        logic [31:0]      data2;
        logic [31:0]      data3;
        fp_operation_type op;
        logic [2:0]       rm;
        logic             enable;
    } fp_exe_in_type;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_exe_out_type;

    // Field order top-down maps to bits [155:0].
    typedef struct packed {
        logic [31:0] data1;     // [155:124]
        logic [31:0] data2;     // [123:92]
        logic [31:0] data3;     // [91:60]
        logic [31:0] result;    // [59:28]
        logic [2:0]  pad_27_25;
        logic [4:0]  flags;     // [24:20]
        logic        pad_19;
        logic [2:0]  rm;        // [18:16]
        logic [1:0]  pad_15_14;
        logic [1:0]  op;        // [13:12]
        logic [1:0]  pad_11_10;
        logic [9:0]  opcode;    // [9:0]
    } fp_vec_rec_type;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] data3;
        logic [2:0]  rm;
        logic [1:0]  op;
        logic [9:0]  opcode;
    } fp_vec_inflight_type;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fp_vec_state_e;

    function automatic logic [FP_VEC_OPC_W-1:0] fp_vec_opcode_of(input fp_operation_type op);
        logic [FP_VEC_OPC_W-1:0] opc;
        opc                         = '0;
        opc[FP_VEC_OPCODE_FMADD]    = op.fmadd;
        opc[FP_VEC_OPCODE_FADD]     = op.fadd;
        opc[FP_VEC_OPCODE_FSUB]     = op.fsub;
        opc[FP_VEC_OPCODE_FMUL]     = op.fmul;
        opc[FP_VEC_OPCODE_FDIV]     = op.fdiv;
        opc[FP_VEC_OPCODE_FSQRT]    = op.fsqrt;
        opc[FP_VEC_OPCODE_FCMP]     = op.fcmp;
        opc[FP_VEC_OPCODE_FCVT_I2F] = op.fcvt_i2f;
        opc[FP_VEC_OPCODE_FCVT_F2I] = op.fcvt_f2i;
        return opc;
    endfunction

endpackage

// File: rtl/fp_vector_logger_fifo.sv
// fp_vec_fifo: synchronous FIFO with a registered head word.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, wdata_i write request and data (ignored when full without pop)
//   pop_i           remove head (ignored when empty)
//   head_o          registered copy of the oldest entry
//   empty_o, full_o registered occupancy flags
module fp_vec_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d, count_rem;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty_q, full_q;
    logic             push_eff, pop_eff;

    always_comb begin
        pop_eff   = pop_i & ~empty_q;
        push_eff  = push_i & (~full_q | pop_eff);
        rptr_d    = rptr_q + AW'(pop_eff);
        wptr_d    = wptr_q + AW'(push_eff);
        count_rem = count_q - (AW+1)'(pop_eff);
        count_d   = count_rem + (AW+1)'(push_eff);
        // Nothing left behind the popped word: the head comes straight from
        // the write port (or stays stale when idle). Otherwise it is the
        // already-stored entry at the new read pointer.
        if (count_rem == '0) begin
            head_d = push_eff ? wdata_i : head_q;
        end else begin
            head_d = mem_q[rptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            head_q  <= head_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == (AW+1)'(DEPTH));
        end
    end

    assign head_o  = head_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/fp_vector_logger.sv
// fp_vector_logger: captures each completed fp_unit operation as a 156-bit
// vector record. Issued operands wait in an in-flight FIFO; each unit ready
// pops the oldest, merges result/flags and queues the record for the sink.
//   clock, reset            clock, asynchronous active-low reset
//   fp_exe_i                request bundle seen by fp_unit
//   fp_exe_o                fp_unit response bundle
//   rec_data/valid/ready    record stream to the trace sink
//   err_overflow/drop/orphan sticky error flags (any one halts capture)
//   rec_count               records accepted by the sink, wraps
//   dbg_state               current run state
//
// Handshake: a record transfers on every rising edge where rec_valid and
// rec_ready are both 1. rec_valid never depends on rec_ready, and rec_data
// stays constant while rec_valid is 1 and rec_ready is 0.
module fp_vector_logger
    import fp_wire::*;
#(
    parameter int INFLIGHT_DEPTH = 8,
    parameter int OUT_DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  fp_exe_in_type           fp_exe_i,
    input  fp_exe_out_type          fp_exe_o,
    output logic [FP_VEC_REC_W-1:0] rec_data,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic                    err_overflow,
    output logic                    err_drop,
    output logic                    err_orphan,
    output logic [31:0]             rec_count,
    output fp_vec_state_e           dbg_state
);

    localparam int IF_W = $bits(fp_vec_inflight_type);

    fp_vec_state_e       state_q, state_d;
    logic                err_overflow_q, err_overflow_d;
    logic                err_drop_q, err_drop_d;
    logic                err_orphan_q, err_orphan_d;
    logic [31:0]         rec_count_q, rec_count_d;

    logic                issue;
    logic                if_push, if_pop, if_empty, if_full;
    logic                out_push, out_pop, out_empty, out_full;
    logic [IF_W-1:0]     if_head_raw;
    logic [FP_VEC_REC_W-1:0] out_head_raw;
    fp_vec_inflight_type if_entry, if_head;
    fp_vec_rec_type      rec_w;

    assign if_head = fp_vec_inflight_type'(if_head_raw);

    always_comb begin
        if_entry        = '0;
        if_entry.data1  = fp_exe_i.data1;
        if_entry.data2  = fp_exe_i.data2;
        if_entry.data3  = fp_exe_i.data3;
        if_entry.rm     = fp_exe_i.rm;
        if_entry.op     = fp_exe_i.op.fcvt_op;
        if_entry.opcode = fp_vec_opcode_of(fp_exe_i.op);
    end

    always_comb begin
        rec_w        = '0;
        rec_w.data1  = if_head.data1;
        rec_w.data2  = if_head.data2;
        rec_w.data3  = if_head.data3;
        rec_w.result = fp_exe_o.result;
        rec_w.flags  = fp_exe_o.flags;
        rec_w.rm     = if_head.rm;
        rec_w.op     = if_head.op;
        rec_w.opcode = if_head.opcode;
    end

    // Run-state next-state and FIFO control. A ready always pairs with an
    // entry issued in an earlier cycle, so the empty check ignores any issue
    // arriving in the same cycle, while the full check credits the pop.
    always_comb begin
        state_d        = state_q;
        err_overflow_d = err_overflow_q;
        err_drop_d     = err_drop_q;
        err_orphan_d   = err_orphan_q;
        rec_count_d    = rec_count_q;
        if_push        = 1'b0;
        if_pop         = 1'b0;
        out_push       = 1'b0;
        issue          = fp_exe_i.enable & (|fp_vec_opcode_of(fp_exe_i.op));
        out_pop        = ~out_empty & rec_ready;

        if (out_pop) begin
            rec_count_d = rec_count_q + 32'd1;
        end

        case (state_q)
            ST_RUN: begin
                if (fp_exe_o.ready) begin
                    if (if_empty) begin
                        err_orphan_d = 1'b1;
                    end else begin
                        if_pop = 1'b1;
                        if (out_full && !out_pop) begin
                            err_drop_d = 1'b1;
                        end else begin
                            out_push = 1'b1;
                        end
                    end
                end
                if (issue) begin
                    if (if_full && !if_pop) begin
                        err_overflow_d = 1'b1;
                    end else begin
                        if_push = 1'b1;
                    end
                end
                if (err_orphan_d || err_drop_d || err_overflow_d) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            err_overflow_q <= 1'b0;
            err_drop_q     <= 1'b0;
            err_orphan_q   <= 1'b0;
            rec_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            err_overflow_q <= err_overflow_d;
            err_drop_q     <= err_drop_d;
            err_orphan_q   <= err_orphan_d;
            rec_count_q    <= rec_count_d;
        end
    end

    fp_vec_fifo #(
        .WIDTH (IF_W),
        .DEPTH (INFLIGHT_DEPTH)
    ) u_inflight_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (if_push),
        .wdata_i (IF_W'(if_entry)),
        .pop_i   (if_pop),
        .head_o  (if_head_raw),
        .empty_o (if_empty),
        .full_o  (if_full)
    );

    fp_vec_fifo #(
        .WIDTH (FP_VEC_REC_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (out_push),
        .wdata_i (FP_VEC_REC_W'(rec_w)),
        .pop_i   (out_pop),
        .head_o  (out_head_raw),
        .empty_o (out_empty),
        .full_o  (out_full)
    );

    assign rec_data     = out_head_raw;
    assign rec_valid    = ~out_empty;
    assign err_overflow = err_overflow_q;
    assign err_drop     = err_drop_q;
    assign err_orphan   = err_orphan_q;
    assign rec_count    = rec_count_q;
    assign dbg_state    = state_q;

endmodule
